// File: rtl/rx_frame_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the UART RX frame controller.
package rx_frame_ctrl_pkg;

   localparam int WIDTH = 8;
   localparam int OVS   = 8;

   localparam logic [2:0] SMP_E0 = 3'd3;
   localparam logic [2:0] SMP_E1 = 3'd4;
   localparam logic [2:0] SMP_E2 = 3'd5;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } rx_state_t;

   function automatic logic maj3(input logic a,
                                 input logic b,
                                 input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/rx_frame_ctrl_if.sv
// Signal bundle between the RX line/deserializer side and rx_frame_ctrl.
interface rx_frame_ctrl_if #(
   parameter int DATA_W = 8
);
   logic              i_rx_in;
   logic              i_par_en;
   logic              i_par_typ;
   logic [DATA_W-1:0] i_deser_data;
   logic [2:0]        o_edge_cnt;
   logic              o_sampled_bit;
   logic              o_en_deser;
   logic              o_par_err;
   logic              o_stp_err;
   logic              o_data_valid;

   modport master (
      output i_rx_in, i_par_en, i_par_typ, i_deser_data,
      input  o_edge_cnt, o_sampled_bit, o_en_deser,
      input  o_par_err, o_stp_err, o_data_valid
   );

   modport slave (
      input  i_rx_in, i_par_en, i_par_typ, i_deser_data,
      output o_edge_cnt, o_sampled_bit, o_en_deser,
      output o_par_err, o_stp_err, o_data_valid
   );
endinterface

// File: rtl/rx_edge_bit_cnt.sv
// Oversample edge counter (wraps 7->0) and data bit counter.
module rx_edge_bit_cnt #(
   parameter int BIT_W = 3
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             edge_en,
   input  logic             edge_clr,
   input  logic             bit_inc,
   input  logic             bit_clr,
   output logic [2:0]       edge_cnt,
   output logic [BIT_W-1:0] bit_cnt
);

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst)
         edge_cnt <= '0;
      else if (edge_clr)
         edge_cnt <= '0;
      else if (edge_en)
         edge_cnt <= edge_cnt + 3'd1;
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst)
         bit_cnt <= '0;
      else if (bit_clr)
         bit_cnt <= '0;
      else if (bit_inc)
         bit_cnt <= bit_cnt + 1'b1;
   end

endmodule

// File: rtl/rx_frame_ctrl.sv
// UART RX frame FSM: start/data/parity/stop tracking, 3-tap majority sampler, checks.
// Optional RX_SYNC_EN adds a 2-flop input synchronizer on i_rx_in.
module rx_frame_ctrl
   import rx_frame_ctrl_pkg::*;
#(
   parameter int DATA_W = WIDTH
) (
   input  logic           i_clk,
   input  logic           i_rst,
   rx_frame_ctrl_if.slave bus
);

   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

   rx_state_t        state, state_nxt;
   logic             rx;
   logic [2:0]       edge_cnt;
   logic [BIT_W-1:0] bit_cnt;
   logic             bit_end;
   logic             s3, s4, sampled;
   logic             par_err, stp_err, data_valid;
   logic             exp_par;
   logic             en_deser, edge_clr, bit_inc, bit_clr;

`ifdef RX_SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst)
         sync_q <= 2'b11;
      else
         sync_q <= {sync_q[0], bus.i_rx_in};
   end

   assign rx = sync_q[1];
`else
   assign rx = bus.i_rx_in;
`endif

   assign bit_end = (edge_cnt == 3'd7);

   rx_edge_bit_cnt #(
      .BIT_W (BIT_W)
   ) u_cnt (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .edge_en  (~edge_clr),
      .edge_clr (edge_clr),
      .bit_inc  (bit_inc),
      .bit_clr  (bit_clr),
      .edge_cnt (edge_cnt),
      .bit_cnt  (bit_cnt)
   );

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst)
         state <= RX_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         RX_IDLE:
            if (!rx)
               state_nxt = RX_START;
         RX_START:
            if (bit_end)
               state_nxt = sampled ? RX_IDLE : RX_DATA;
         RX_DATA:
            if (bit_end && bit_cnt == LAST_BIT)
               state_nxt = bus.i_par_en ? RX_PARITY : RX_STOP;
         RX_PARITY:
            if (bit_end)
               state_nxt = RX_STOP;
         RX_STOP:
            if (bit_end)
               state_nxt = RX_IDLE;
         default:
            state_nxt = RX_IDLE;
      endcase
   end

   always_comb begin
      en_deser = (state == RX_DATA);
      edge_clr = (state == RX_IDLE);
      bit_inc  = en_deser & bit_end;
      bit_clr  = ~en_deser;
   end

   // Majority of three mid-bit taps rejects a single-cycle glitch.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         s3      <= 1'b1;
         s4      <= 1'b1;
         sampled <= 1'b1;
      end else begin
         if (edge_cnt == SMP_E0)
            s3 <= rx;
         if (edge_cnt == SMP_E1)
            s4 <= rx;
         if (edge_cnt == SMP_E2)
            sampled <= maj3(s3, s4, rx);
      end
   end

   assign exp_par = bus.i_par_typ ? ~^bus.i_deser_data
                                  : ^bus.i_deser_data;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
         data_valid <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         if (state == RX_IDLE && !rx) begin
            par_err <= 1'b0;
            stp_err <= 1'b0;
         end
         if (state == RX_PARITY && bit_end)
            par_err <= (sampled != exp_par);
         if (state == RX_STOP && bit_end) begin
            stp_err    <= ~sampled;
            data_valid <= sampled & ~par_err;
         end
      end
   end

   assign bus.o_edge_cnt    = edge_cnt;
   assign bus.o_sampled_bit = sampled;
   assign bus.o_en_deser    = en_deser;
   assign bus.o_par_err     = par_err;
   assign bus.o_stp_err     = stp_err;
   assign bus.o_data_valid  = data_valid;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Scoreboard bench for rx_frame_ctrl with a behavioural LSB-first deserializer.
module tb_rx_frame_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   rx_frame_ctrl_if #(.DATA_W(8)) bus ();

   rx_frame_ctrl #(.DATA_W(8)) dut (
      .i_clk (clk),
      .i_rst (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [7:0] data;
      int         vld;
      int         en;
      logic       pe;
      logic       se;
   } exp_t;

   exp_t sb[$];

   int total = 0;
   int bad   = 0;
   int vld_tot = 0;
   int en_tot  = 0;
   logic [7:0] deser;
   logic [7:0] last_d = 8'h00;

   assign bus.i_deser_data = deser;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         deser <= 8'h00;
      else if (bus.o_en_deser && bus.o_edge_cnt == 3'd7)
         deser <= {bus.o_sampled_bit, deser[7:1]};
   end

   always @(negedge clk) begin
      if (bus.o_data_valid)
         vld_tot++;
      if (bus.o_en_deser)
         en_tot++;
   end

   task automatic chk(input string tag,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   task automatic chk_rst(input string tag);
      chk(tag,
          32'({bus.o_edge_cnt, bus.o_sampled_bit, bus.o_en_deser,
               bus.o_par_err, bus.o_stp_err, bus.o_data_valid}),
          32'(8'b000_1_0000));
   endtask

   task automatic drive_bit(input logic v, input int gl, input int idx);
      for (int j = 0; j < 8; j++) begin
         @(posedge clk);
         #1;
         bus.i_rx_in = (gl == idx && j == 5) ? ~v : v;
         if (idx == 0 && j == 2) begin
            @(negedge clk);
            chk("flg_clr", 32'({bus.o_par_err, bus.o_stp_err}), 32'd0);
         end
         if (gl == idx && j == 7) begin
            @(negedge clk);
            chk("smp_maj", 32'(bus.o_sampled_bit), 32'(v));
         end
      end
   endtask

   task automatic check_frame(input int bv, input int be);
      exp_t e;
      e = sb.pop_front();
      chk("vld", 32'(vld_tot - bv), 32'(e.vld));
      chk("en", 32'(en_tot - be), 32'(e.en));
      chk("par", 32'(bus.o_par_err), 32'(e.pe));
      chk("stp", 32'(bus.o_stp_err), 32'(e.se));
      chk("data", 32'(deser), 32'(e.data));
   endtask

   // gl = index of frame bit (0=start, 1..8=data) to glitch, -1 = none
   task automatic send_frame(input logic [7:0] d, input logic pe,
                             input logic pt, input logic flip,
                             input logic stop, input int gl);
      exp_t e;
      int bv, be, idx;
      logic pbit;
      pbit = (pt ? ~^d : ^d) ^ flip;
      e.data = d;
      e.en   = 64;
      e.pe   = pe & flip;
      e.se   = ~stop;
      e.vld  = (stop && !(pe && flip)) ? 1 : 0;
      sb.push_back(e);
      bv = vld_tot;
      be = en_tot;
      bus.i_par_en  = pe;
      bus.i_par_typ = pt;
      drive_bit(1'b0, gl, 0);
      for (int b = 0; b < 8; b++)
         drive_bit(d[b], gl, b + 1);
      idx = 9;
      if (pe) begin
         drive_bit(pbit, gl, idx);
         idx++;
      end
      drive_bit(stop, gl, idx);
      @(posedge clk);
      #1;
      bus.i_rx_in = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_frame(bv, be);
      last_d = d;
   endtask

   initial begin
      exp_t e;
      int bv, be;
      bus.i_rx_in   = 1'b1;
      bus.i_par_en  = 1'b0;
      bus.i_par_typ = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_rst("rst0");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);

      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1);
      send_frame(8'h0F, 1'b1, 1'b0, 1'b0, 1'b1, -1);
      send_frame(8'h0F, 1'b1, 1'b0, 1'b1, 1'b1, -1);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1);

      // 3-cycle low pulse on an idle line must be rejected as a glitch
      e.data = last_d;
      e.vld  = 0;
      e.en   = 0;
      e.pe   = 1'b0;
      e.se   = 1'b0;
      sb.push_back(e);
      bv = vld_tot;
      be = en_tot;
      @(posedge clk);
      #1;
      bus.i_rx_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      bus.i_rx_in = 1'b1;
      repeat (14) @(posedge clk);
      @(negedge clk);
      check_frame(bv, be);
      chk("edge_idle", 32'(bus.o_edge_cnt), 32'd0);

      send_frame(8'hB6, 1'b1, 1'b1, 1'b0, 1'b1, -1);
      send_frame(8'hB6, 1'b1, 1'b1, 1'b1, 1'b1, -1);
      send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 3);
      send_frame(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, -1);

      // abort in the middle of data bit 3
      bus.i_par_en = 1'b0;
      @(posedge clk);
      #1;
      bus.i_rx_in = 1'b0;
      repeat (8 + 3 * 8 + 4) begin
         @(posedge clk);
         #1;
      end
      chk("en_mid", 32'(bus.o_en_deser), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_rst("rst_mid");
      chk("deser_rst", 32'(deser), 32'd0);
      bus.i_rx_in = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_rst("rst_post");

      send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, -1);

      repeat (4) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rx_frame_ctrl.md
Name: rx_frame_ctrl

Overview:
- Receive-side frame controller of the UART RX path.
- Runs on the 8x-oversampling clock and tracks the serial line through start, data, optional parity and stop bits.
- Generates edge count, majority-voted sampled bit and deserializer enable for the downstream deserializer.
- Checks parity against the deserializer's assembled word, checks the stop bit, and flags frame completion.

Parameters:
- DATA_W, 8, data bits per frame; must equal `WIDTH.
- OVS, 8, oversampling ratio; fixed at 8 so the edge counter is 3 bits.

Ports:
- i_clk  in  1  oversampling clock (8x baud); the single clock.
- i_rst  in  1  asynchronous, active-low reset.
- i_rx_in  in  1  serial RX line, idle high.
- i_par_en  in  1  1 = frame carries a parity bit.
- i_par_typ  in  1  0 = even parity, 1 = odd parity.
- i_deser_data  in  DATA_W  word assembled by the deserializer.
- o_edge_cnt  out  3  oversample index within the current bit, 0..7.
- o_sampled_bit  out  1  majority-voted value of the current bit.
- o_en_deser  out  1  high throughout the DATA state.
- o_par_err  out  1  parity mismatch on the last frame.
- o_stp_err  out  1  stop bit sampled low on the last frame.
- o_data_valid  out  1  one-cycle pulse: frame received without error.

Behaviour:
- Reset values:
  - o_edge_cnt=0, o_sampled_bit=1, o_en_deser=0, o_par_err=0, o_stp_err=0, o_data_valid=0.
  - Internal bit counter 0; state IDLE.
  - Reset asserted mid-frame aborts immediately; no partial-frame outputs afterwards.
- Edge counter:
  - Held at 0 in IDLE.
  - In any other state, increments each cycle and wraps 7->0.
  - "Bit end" = cycle with edge_cnt==7.
- Bit counter:
  - Counts data bits; increments at bit end in DATA.
  - Cleared when leaving DATA and in IDLE.
- Sampler:
  - Registers rx at edge_cnt 3, 4 and 5.
  - o_sampled_bit updates at the clock edge where edge_cnt==5, using majority(s3, s4, rx).
  - Value is stable for edges 6 and 7, so the deserializer capture at edge 7 is valid.
- FSM:
  - IDLE: when rx==0, next state START with edge_cnt=0 in the first START cycle. Entering START clears o_par_err and o_stp_err.
  - START: at bit end, sampled_bit==0 -> DATA; sampled_bit==1 (glitch) -> IDLE, with no flag and no valid.
  - DATA: o_en_deser=1, decoded from state (no register delay). At bit end with bit_cnt==DATA_W-1 -> PARITY if i_par_en, else STOP. i_par_en is sampled only at this transition.
  - PARITY: at bit end, expected = ^i_deser_data when even, ~^i_deser_data when odd. o_par_err <= (sampled_bit != expected). Next state STOP. i_deser_data is already complete here, because the deserializer updated at the last data bit end.
  - STOP: at bit end, o_stp_err <= ~sampled_bit. o_data_valid pulses high for exactly the next cycle iff the stop bit is 1 and o_par_err==0. Next state IDLE.
- Back-to-back frames: rx low in the first IDLE cycle after STOP starts a new frame. o_data_valid of the previous frame still pulses.
- Error flags hold until the next START entry or reset.
- Line held low in IDLE (break condition): a start is detected, then a stop error at STOP. The FSM re-enters START repeatedly while the line stays low.

Optional Feature:
- Macro RX_SYNC_EN.
- Defined: i_rx_in passes through a 2-flop synchronizer, reset to 1, before detection and sampling. All detection and sampling is delayed 2 cycles relative to the pin.
- Undefined: i_rx_in is used directly; the upstream logic guarantees it is synchronous to i_clk.

Decomposition:
- Shared package (parameters.v):
  - `WIDTH (existing), `OVS=8.
  - State encodings `RX_IDLE, `RX_START, `RX_DATA, `RX_PARITY, `RX_STOP as 3-bit constants.
  - Sample-edge constants `SMP_E0=3, `SMP_E1=4, `SMP_E2=5.
- One sub-module: rx_edge_bit_cnt, the edge and bit counters with enable/clear. FSM, sampler and checks stay in rx_frame_ctrl.

Test Plan:
- Frame 0xA5, LSB first, i_par_en=0, 8 cycles per bit -> o_en_deser high for exactly 64 cycles; o_data_valid pulses once; deserializer holds 0xA5; no error flags.
- Frame 0x0F, i_par_en=1, i_par_typ=0, parity bit 0 -> o_par_err=0, o_data_valid pulses. Same frame with parity bit 1 -> o_par_err=1 and no pulse.
- Frame 0x3C with stop bit driven 0 -> o_stp_err=1, no o_data_valid. Flag clears on the next start bit.
- rx pulsed low for 3 cycles, then high -> FSM returns to IDLE at the first bit end; o_en_deser never asserted; no flags.
- Single-cycle glitch at edge 4 of a data bit (1->0->1) -> o_sampled_bit stays 1 (majority); data value correct.
- i_rst deasserted-to-low mid-DATA (bit 3) -> all outputs at reset values that same cycle. A following clean 0x55 frame is received correctly.
